local_ctrl_layer4: RTL and testbench

- Consumer side of the 64-entry layer-3 temp buffer.
- After layer 3 fills the buffer, this block:
  - reads the 64 activations back for each of the 10 output neurons;
  - fetches the matching weights;
  - accumulates signed dot products and reports each score;
  - tracks the argmax to produce the classified digit.
- It releases the temp buffer back to the writer once the last read is issued.

---
 rtl/local_ctrl_layer4.sv | 183 ++++++++++++++++++
 tb/tb_local_ctrl_layer4.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/local_ctrl_layer4.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | local_ctrl_layer4: reads the layer-3 temp buffer 10x, forms signed dot     |
// | products against the weight ROM and reports scores plus an argmax class.   |
// | Option macro: LAYER4_ARGMAX_EN (builds the argmax comparator).             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module local_ctrl_layer4 #(
  parameter int DATA_W = 8,
  parameter int WGT_W  = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     start_i,
  output logic                     temp_rd_en_o,
  output logic [5:0]               temp_rd_addr_o,
  input  logic [DATA_W-1:0]        temp_rd_data_i,
  output logic                     w_en_o,
  output logic [9:0]               w_addr_o,
  input  logic [WGT_W-1:0]         w_data_i,
  output logic                     temp_rd_done_o,
  output logic                     score_valid_o,
  output logic [3:0]               score_idx_o,
  output logic signed [ACC_W-1:0]  score_o,
  output logic [3:0]               class_o,
  output logic                     done_o
);

  localparam int PROD_W = DATA_W + WGT_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FINAL = 2'd3;

  logic [1:0]               r_state;
  logic [5:0]               r_idx;
  logic [3:0]               r_neuron;
  logic [9:0]               r_waddr;
  logic                     r_rd_en;
  logic                     r_drain;
  logic                     r_tdone;
  logic                     r_done;

  logic                     r_p_valid;
  logic                     r_p_first;
  logic                     r_p_last;
  logic [3:0]               r_p_neuron;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_sv;
  logic [3:0]               r_sidx;

  logic                     w_last_rd;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;

  assign w_last_rd  = (r_idx == 6'd63) && (r_neuron == 4'd9);
  assign w_prod     = $signed(temp_rd_data_i) * $signed(w_data_i);
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  // The first element of each neuron reloads the accumulator, so no clear cycle is needed.
  assign w_sum      = r_p_first ? w_prod_ext : (r_acc + w_prod_ext);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= ST_IDLE;
      r_idx    <= 6'd0;
      r_neuron <= 4'd0;
      r_waddr  <= 10'd0;
      r_rd_en  <= 1'b0;
      r_drain  <= 1'b0;
      r_tdone  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tdone <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state  <= ST_READ;
            r_rd_en  <= 1'b1;
            r_idx    <= 6'd0;
            r_neuron <= 4'd0;
            r_waddr  <= 10'd0;
          end
        end
        ST_READ: begin
          if (w_last_rd) begin
            r_state  <= ST_DRAIN;
            r_rd_en  <= 1'b0;
            r_idx    <= 6'd0;
            r_neuron <= 4'd0;
            r_waddr  <= 10'd0;
            r_tdone  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 6'd1;
            r_waddr <= r_waddr + 10'd1;
            if (r_idx == 6'd63) begin
              r_neuron <= r_neuron + 4'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain) begin
            r_state <= ST_FINAL;
            r_drain <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        ST_FINAL: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_p_valid  <= 1'b0;
      r_p_first  <= 1'b0;
      r_p_last   <= 1'b0;
      r_p_neuron <= 4'd0;
      r_acc      <= '0;
      r_sv       <= 1'b0;
      r_sidx     <= 4'd0;
    end else begin
      r_p_valid  <= r_rd_en;
      r_p_first  <= (r_idx == 6'd0);
      r_p_last   <= (r_idx == 6'd63);
      r_p_neuron <= r_neuron;
      r_sv       <= 1'b0;
      if (r_p_valid) begin
        r_acc <= w_sum;
        if (r_p_last) begin
          r_sv   <= 1'b1;
          r_sidx <= r_p_neuron;
        end
      end
    end
  end

`ifdef LAYER4_ARGMAX_EN
  logic signed [ACC_W-1:0] r_best;
  logic [3:0]              r_best_idx;
  logic [3:0]              r_class;

  // Compared on the final sum so the last neuron is settled before FINAL loads class.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_best     <= '0;
      r_best_idx <= 4'd0;
      r_class    <= 4'd0;
    end else begin
      if (r_p_valid && r_p_last && ((r_p_neuron == 4'd0) || (w_sum > r_best))) begin
        r_best     <= w_sum;
        r_best_idx <= r_p_neuron;
      end
      if ((r_state == ST_DRAIN) && r_drain) begin
        r_class <= r_best_idx;
      end
    end
  end

  assign class_o = r_class;
`else
  assign class_o = 4'd0;
`endif

  assign temp_rd_en_o   = r_rd_en;
  assign temp_rd_addr_o = r_idx;
  assign w_en_o         = r_rd_en;
  assign w_addr_o       = r_waddr;
  assign temp_rd_done_o = r_tdone;
  assign score_valid_o  = r_sv;
  assign score_idx_o    = r_sidx;
  assign score_o        = r_acc;
  assign done_o         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_local_ctrl_layer4.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_local_ctrl_layer4: scoreboard bench for local_ctrl_layer4.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_local_ctrl_layer4;

  localparam int DATA_W = 8;
  localparam int WGT_W  = 8;
  localparam int ACC_W  = 24;
  localparam int FAR    = -1000000;

  logic                    clk = 1'b0;
  logic                    rstn_i;
  logic                    start_i;
  logic                    temp_rd_en_o;
  logic [5:0]              temp_rd_addr_o;
  logic [DATA_W-1:0]       temp_rd_data_i;
  logic                    w_en_o;
  logic [9:0]              w_addr_o;
  logic [WGT_W-1:0]        w_data_i;
  logic                    temp_rd_done_o;
  logic                    score_valid_o;
  logic [3:0]              score_idx_o;
  logic signed [ACC_W-1:0] score_o;
  logic [3:0]              class_o;
  logic                    done_o;

  local_ctrl_layer4 #(.DATA_W(DATA_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .start_i        (start_i),
    .temp_rd_en_o   (temp_rd_en_o),
    .temp_rd_addr_o (temp_rd_addr_o),
    .temp_rd_data_i (temp_rd_data_i),
    .w_en_o         (w_en_o),
    .w_addr_o       (w_addr_o),
    .w_data_i       (w_data_i),
    .temp_rd_done_o (temp_rd_done_o),
    .score_valid_o  (score_valid_o),
    .score_idx_o    (score_idx_o),
    .score_o        (score_o),
    .class_o        (class_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  // After edge e, cyc == e and the running period is cycle e+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DATA_W-1:0] act [64];
  logic signed [WGT_W-1:0]  wgt [640];
  always @(posedge clk) begin
    if (temp_rd_en_o) temp_rd_data_i <= act[temp_rd_addr_o];
    if (w_en_o)       w_data_i       <= wgt[w_addr_o];
  end

  typedef struct { int c; int idx; int score; } sc_t;
  typedef struct { int c; int cls; } dn_t;
  sc_t sb_q[$];
  int  td_q[$];
  dn_t dn_q[$];
  int  rd_base = FAR;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act_v, input longint exp_v);
    n_tests++;
    if (act_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act_v, exp_v, cyc + 1);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected pulse, expected none (cycle %0d)", name, cyc + 1);
  endtask

  function automatic logic [63:0] outs();
    return {11'd0, temp_rd_en_o, temp_rd_addr_o, w_en_o, w_addr_o, temp_rd_done_o,
            score_valid_o, score_idx_o, score_o, class_o, done_o};
  endfunction

  function automatic int exp_class(input int v);
`ifdef LAYER4_ARGMAX_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Hand-computed expectations: pattern 0 gives 64*k, pattern 1 gives 127*-1*64 except neuron 3.
  task automatic push_run(input int n, input int pat);
    for (int k = 0; k < 10; k++) begin
      int s;
      if (pat == 0) s = 64 * k;
      else          s = (k == 3) ? -1040384 : -8128;
      sb_q.push_back('{n + 66 + 64 * k, k, s});
    end
    td_q.push_back(n + 641);
    dn_q.push_back('{n + 643, exp_class((pat == 0) ? 9 : 0)});
  endtask

  always @(negedge clk) begin : mon
    int cur;
    logic in_rng;
    sc_t e;
    dn_t d;
    int  t;
    cur = cyc + 1;
    if (rstn_i) begin
      in_rng = (cur >= rd_base) && (cur < rd_base + 640);
      check("rd_en", temp_rd_en_o, in_rng);
      check("w_en", w_en_o, in_rng);
      if (temp_rd_en_o && in_rng) begin
        check("w_addr", w_addr_o, cur - rd_base);
        check("temp_addr", temp_rd_addr_o, (cur - rd_base) % 64);
      end
      if (score_valid_o) begin
        if (sb_q.size() == 0) fail_now("score_valid");
        else begin
          e = sb_q.pop_front();
          check("score_cycle", cur, e.c);
          check("score_idx", score_idx_o, e.idx);
          check("score", score_o, e.score);
        end
      end
      if (temp_rd_done_o) begin
        if (td_q.size() == 0) fail_now("temp_rd_done");
        else begin
          t = td_q.pop_front();
          check("temp_rd_done_cycle", cur, t);
        end
      end
      if (done_o) begin
        if (dn_q.size() == 0) fail_now("done");
        else begin
          d = dn_q.pop_front();
          check("done_cycle", cur, d.c);
          check("class", class_o, d.cls);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc + 1 < c) @(negedge clk);
  endtask

  task automatic start_now(output int n);
    start_i = 1'b1;
    n       = cyc + 1;
    rd_base = n + 1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic pulse_start_at(input int c);
    wait_until(c);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic load_pat(input int pat);
    for (int i = 0; i < 64; i++) act[i] = (pat == 0) ? 8'sd1 : 8'sd127;
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < 64; i++)
        wgt[k * 64 + i] = (pat == 0) ? WGT_W'(k) : ((k == 3) ? -8'sd128 : -8'sd1);
  endtask

  initial begin
    int n, n2;
    rstn_i  = 1'b0;
    start_i = 1'b0;
    load_pat(0);
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rstn_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_outputs", outs(), 0);
    end

    // Run with ignored start pulses, then back-to-back second run.
    start_now(n);
    push_run(n, 0);
    pulse_start_at(n + 100);
    pulse_start_at(n + 643);
    start_now(n2);
    check("second_start_cycle", n2, n + 644);
    push_run(n2, 0);
    wait_until(n2 + 660);

    // Negative weights and ties.
    load_pat(1);
    start_now(n);
    push_run(n, 1);
    wait_until(n + 660);

    // Abort mid-READ with asynchronous reset.
    load_pat(0);
    start_now(n);
    push_run(n, 0);
    wait_until(n + 300);
    #2;
    rstn_i  = 1'b0;
    rd_base = FAR;
    sb_q.delete();
    td_q.delete();
    dn_q.delete();
    #1;
    check("abort_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    repeat (700) @(negedge clk);
    start_now(n);
    push_run(n, 0);
    wait_until(n + 660);

    check("score_q_left", sb_q.size(), 0);
    check("tdone_q_left", td_q.size(), 0);
    check("done_q_left", dn_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
